// File: rtl/dphy_pkg.sv
// Shared state encoding, LP line codes and byte helpers for the D-PHY HS burst sequencer.
package dphy_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StLpx01,
    StLpx00,
    StHsZero,
    StSync,
    StData,
    StTrail,
    StExit
  } state_t;

  localparam logic [1:0] LP_11 = 2'b11;
  localparam logic [1:0] LP_01 = 2'b01;
  localparam logic [1:0] LP_00 = 2'b00;

  localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hB8;

  function automatic logic [1:0] lp_code(input state_t st);
    case (st)
      StIdle, StExit: return LP_11;
      StLpx01:        return LP_01;
      default:        return LP_00;
    endcase
  endfunction

  // Trail holds the complement of the last serial bit (bit7) of the final byte.
  function automatic logic [7:0] trail_byte(input logic [7:0] last_byte);
    return last_byte[7] ? 8'h00 : 8'hFF;
  endfunction

endpackage

// File: rtl/dphy_timer.sv
// Loadable down-counter that parks at zero; zero flags the end of a timed state.
module dphy_timer #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  output logic             zero
);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (count != '0) begin
      count <= count - CNT_W'(1);
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/dphy_hs_burst_sequencer.sv
// Lane-0 LP/HS control and byte lanes for one D-PHY HS burst, from LP-11 back to LP-11.
module dphy_hs_burst_sequencer
  import dphy_pkg::*;
#(
  parameter int unsigned T_LPX      = 2,
  parameter int unsigned T_HS_ZERO  = 6,
  parameter int unsigned T_HS_TRAIL = 3,
  parameter int unsigned T_HS_EXIT  = 4,
  parameter int unsigned CNT_W      = 8,
  parameter logic [7:0]  SYNC_BYTE  = SYNC_BYTE_DEFAULT
) (
  input  logic       i_clk,
  input  logic       reset_n,
  input  logic       i_start,
  input  logic       i_byte_valid,
  input  logic [7:0] i_byte_D0,
  input  logic [7:0] i_byte_D1,
  input  logic       i_last,
  output logic       o_byte_ready,
  output logic [1:0] o_LP,
  output logic       o_HS,
  output logic [7:0] o_byte_D0,
  output logic [7:0] o_byte_D1,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_underrun
);

  state_t           state, state_nx;
  logic             tmr_load, tmr_zero, trailing;
  logic [CNT_W-1:0] tmr_val;
  logic             beat_ok, data_end;

  assign beat_ok  = o_byte_ready & i_byte_valid;
  // DATA ends on the final beat or on the first starved cycle.
  assign data_end = ~i_byte_valid | i_last;

  dphy_timer #(
    .CNT_W(CNT_W)
  ) u_timer (
    .clk     (i_clk),
    .reset_n (reset_n),
    .load    (tmr_load),
    .load_val(tmr_val),
    .zero    (tmr_zero)
  );

  // TRAIL loads T_HS_TRAIL rather than T_HS_TRAIL-1: its first cycle still shows the final beat.
  always_comb begin
    state_nx = state;
    tmr_load = 1'b0;
    tmr_val  = '0;
    unique case (state)
      StIdle: if (i_start) begin
        state_nx = StLpx01;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_LPX - 1);
      end
      StLpx01: if (tmr_zero) begin
        state_nx = StLpx00;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_LPX - 1);
      end
      StLpx00: if (tmr_zero) begin
        state_nx = StHsZero;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_HS_ZERO - 1);
      end
      StHsZero: if (tmr_zero) begin
        state_nx = StSync;
        tmr_load = 1'b1;
      end
      StSync: state_nx = StData;
      StData: if (data_end) begin
        state_nx = StTrail;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_HS_TRAIL);
      end
      StTrail: if (tmr_zero) begin
        state_nx = StExit;
        tmr_load = 1'b1;
        tmr_val  = CNT_W'(T_HS_EXIT - 1);
      end
      StExit: if (tmr_zero) state_nx = StIdle;
      default: state_nx = StIdle;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!reset_n) begin
      state        <= StIdle;
      trailing     <= 1'b0;
      o_LP         <= LP_11;
      o_HS         <= 1'b0;
      o_byte_D0    <= 8'h00;
      o_byte_D1    <= 8'h00;
      o_byte_ready <= 1'b0;
      o_busy       <= 1'b0;
      o_done       <= 1'b0;
      o_underrun   <= 1'b0;
    end else begin
      state        <= state_nx;
      trailing     <= (state == StTrail);
      o_LP         <= lp_code(state_nx);
      o_HS         <= state_nx inside {StHsZero, StSync, StData, StTrail};
      o_byte_ready <= (state_nx == StData);
      o_busy       <= (state_nx != StIdle);
      o_done       <= (state == StExit) && (state_nx == StIdle);
      o_underrun   <= (state == StData) && !i_byte_valid;
      // Bytes move only on a handshake, so SYNC_BYTE persists through the first DATA cycle.
      unique case (state_nx)
        StSync: begin
          o_byte_D0 <= SYNC_BYTE;
          o_byte_D1 <= SYNC_BYTE;
        end
        StData, StTrail: begin
          if ((state == StTrail) && !trailing) begin
            o_byte_D0 <= trail_byte(o_byte_D0);
            o_byte_D1 <= trail_byte(o_byte_D1);
          end else if (beat_ok) begin
            o_byte_D0 <= i_byte_D0;
            o_byte_D1 <= i_byte_D1;
          end
        end
        default: begin
          o_byte_D0 <= 8'h00;
          o_byte_D1 <= 8'h00;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dphy_hs_burst_sequencer.sv
// Directed bench: default-timing and all-ones-timing sequencers, checked cycle by cycle.
module tb_dphy_hs_burst_sequencer;

  localparam logic [7:0] SYNC = 8'hB8;

  logic       clk = 1'b0;
  logic       rst_n, start_n, start_f, valid, last, fast;
  logic [7:0] d0, d1;
  logic [1:0] lp_n, lp_f;
  logic       hs_n, hs_f, rdy_n, rdy_f, busy_n, busy_f, done_n, done_f, und_n, und_f;
  logic [7:0] q0_n, q1_n, q0_f, q1_f;
  logic [22:0] st_n, st_f, st_s;

  logic [7:0] b0 [4];
  logic [7:0] b1 [4];

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  dphy_hs_burst_sequencer u_dut_n (
    .i_clk       (clk),
    .reset_n     (rst_n),
    .i_start     (start_n),
    .i_byte_valid(valid),
    .i_byte_D0   (d0),
    .i_byte_D1   (d1),
    .i_last      (last),
    .o_byte_ready(rdy_n),
    .o_LP        (lp_n),
    .o_HS        (hs_n),
    .o_byte_D0   (q0_n),
    .o_byte_D1   (q1_n),
    .o_busy      (busy_n),
    .o_done      (done_n),
    .o_underrun  (und_n)
  );

  dphy_hs_burst_sequencer #(
    .T_LPX     (1),
    .T_HS_ZERO (1),
    .T_HS_TRAIL(1),
    .T_HS_EXIT (1)
  ) u_dut_f (
    .i_clk       (clk),
    .reset_n     (rst_n),
    .i_start     (start_f),
    .i_byte_valid(valid),
    .i_byte_D0   (d0),
    .i_byte_D1   (d1),
    .i_last      (last),
    .o_byte_ready(rdy_f),
    .o_LP        (lp_f),
    .o_HS        (hs_f),
    .o_byte_D0   (q0_f),
    .o_byte_D1   (q1_f),
    .o_busy      (busy_f),
    .o_done      (done_f),
    .o_underrun  (und_f)
  );

  // Status word: {lp[22:21], hs, ready, busy, done, underrun, D0[15:8], D1[7:0]}
  assign st_n = {lp_n, hs_n, rdy_n, busy_n, done_n, und_n, q0_n, q1_n};
  assign st_f = {lp_f, hs_f, rdy_f, busy_f, done_f, und_f, q0_f, q1_f};
  assign st_s = fast ? st_f : st_n;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [22:0] pack(input logic [1:0] lp, input logic hs, input logic rdy,
                                       input logic busy, input logic done, input logic und,
                                       input logic [7:0] e0, input logic [7:0] e1);
    return {lp, hs, rdy, busy, done, und, e0, e1};
  endfunction

  function automatic logic [7:0] trail_of(input logic [7:0] b);
    return b[7] ? 8'h00 : 8'hFF;
  endfunction

  // Expected status c cycles after the start is taken (c=0 is the first LP-01 cycle).
  function automatic logic [22:0] expect_at(input int c, input int tl, input int tz,
                                            input int tt, input int te, input int n,
                                            input bit u);
    int s, t0, tend, bi;
    logic [1:0] lp;
    logic hs, rdy, busy, done, und;
    logic [7:0] e0, e1, l0, l1;
    s    = 2 * tl + tz;
    t0   = s + n + 2 + int'(u);
    tend = t0 + tt + te;
    l0   = (n > 0) ? b0[n-1] : SYNC;
    l1   = (n > 0) ? b1[n-1] : SYNC;
    lp = 2'b00; hs = 1'b1; rdy = 1'b0; busy = 1'b1; done = 1'b0; und = 1'b0;
    e0 = 8'h00; e1 = 8'h00;
    if (c < tl) begin
      lp = 2'b01;
      hs = 1'b0;
    end else if (c < 2 * tl) begin
      hs = 1'b0;
    end else if (c < s) begin
      e0 = 8'h00;
    end else if (c <= s + 1) begin
      e0  = SYNC;
      e1  = SYNC;
      rdy = (c == s + 1);
    end else if (c < t0) begin
      bi = c - (s + 2);
      if (bi > n - 1) bi = n - 1;
      e0  = (n > 0) ? b0[bi] : SYNC;
      e1  = (n > 0) ? b1[bi] : SYNC;
      rdy = (c <= s + n + int'(u));
      und = u && (c == s + n + 2);
    end else if (c < t0 + tt) begin
      e0 = trail_of(l0);
      e1 = trail_of(l1);
    end else begin
      lp = 2'b11;
      hs = 1'b0;
      if (c >= tend) begin
        busy = 1'b0;
        done = 1'b1;
      end
    end
    return pack(lp, hs, rdy, busy, done, und, e0, e1);
  endfunction

  // Starts a burst at the current falling edge and checks every cycle up to the done pulse.
  task automatic run_burst(input string name, input bit f, input int n, input bit u,
                           input bit hold);
    int tl, tz, tt, te, tend, idx, extra;
    bit dropped;
    fast = f;
    tl = f ? 1 : 2;
    tz = f ? 1 : 6;
    tt = f ? 1 : 3;
    te = f ? 1 : 4;
    tend = 2 * tl + tz + n + 2 + int'(u) + tt + te;
    idx = 0; extra = 0; dropped = 1'b0;
    if (f) start_f = 1'b1; else start_n = 1'b1;
    valid = 1'b0; last = 1'b0;
    for (int c = 0; c <= tend; c++) begin
      @(negedge clk);
      check_eq($sformatf("%s c%0d", name, c), 32'(st_s), 32'(expect_at(c, tl, tz, tt, te, n, u)));
      check_eq($sformatf("%s glitch c%0d", name, c), 32'(st_s[20] & (st_s[22:21] != 2'b00)), 0);
      if (c == 0) begin
        if (f) start_f = hold; else start_n = hold;
      end
      if (idx < n) begin
        valid = 1'b1; d0 = b0[idx]; d1 = b1[idx]; last = !u && (idx == n - 1);
      end else if (u && !dropped) begin
        valid = 1'b0; last = 1'b0;
        if (st_s[19]) dropped = 1'b1;
      end else if (u) begin
        valid = 1'b1; d0 = 8'hEE; d1 = 8'hEE; last = 1'b0;
      end else begin
        valid = 1'b0; last = 1'b0;
      end
      if (valid && st_s[19]) begin
        if (idx < n) idx++; else extra++;
      end
    end
    valid = 1'b0; last = 1'b0;
    check_eq($sformatf("%s beats", name), idx, n);
    check_eq($sformatf("%s extra", name), extra, 0);
  endtask

  task automatic reset_mid();
    fast = 1'b0; start_n = 1'b1; valid = 1'b0; last = 1'b0;
    @(negedge clk);
    start_n = 1'b0;
    repeat (6) @(negedge clk);
    check_eq("rst pre", 32'(st_s[22:20]), 32'(3'b001));
    rst_n = 1'b0;
    @(negedge clk);
    check_eq("rst abort", 32'(st_s), 32'(pack(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00)));
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; start_n = 1'b0; start_f = 1'b0; valid = 1'b0; last = 1'b0;
    d0 = 8'h00; d1 = 8'h00; fast = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset n", 32'(st_n), 32'(pack(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00)));
    check_eq("reset f", 32'(st_f), 32'(pack(2'b11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 8'h00)));
    rst_n = 1'b1;
    @(negedge clk);

    b0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    b1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst("four", 1'b0, 4, 1'b0, 1'b0);

    b0[0] = 8'h80; b1[0] = 8'h7F;
    run_burst("pol", 1'b0, 1, 1'b0, 1'b0);

    b0 = '{8'h05, 8'h06, 8'h00, 8'h00};
    b1 = '{8'h85, 8'h86, 8'h00, 8'h00};
    run_burst("starve", 1'b0, 2, 1'b1, 1'b0);

    reset_mid();
    b0 = '{8'h01, 8'h02, 8'h03, 8'h04};
    b1 = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_burst("post_rst", 1'b0, 4, 1'b0, 1'b0);

    run_burst("hold", 1'b0, 2, 1'b0, 1'b1);
    run_burst("after_hold", 1'b0, 1, 1'b0, 1'b0);

    run_burst("zero", 1'b0, 0, 1'b1, 1'b0);

    b0 = '{8'h9A, 8'h3C, 8'hC3, 8'h00};
    b1 = '{8'h10, 8'hF0, 8'h0F, 8'h00};
    run_burst("fast", 1'b1, 3, 1'b0, 1'b0);
    run_burst("fast_starve", 1'b1, 1, 1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
